// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - miss handler: dirty-victim writeback, block fetch, cache fill
//
// Ports:
//   clk, rst_b                  clock, asynchronous active-low reset
//   cpu_access, cpu_addr        pending CPU load/store and its byte address
//   cache_hit, cache_dirty      hit and dirty status of the indexed line
//   cache_miss_addr/data_out    victim block address and contents
//   fill_sel/we/addr/data       cache write port takeover during WRITE
//   stall                       holds the CPU pipeline while a miss is serviced
//   mem_req/we/addr/wdata       memory request, held until mem_ack
//   mem_rdata, mem_ack          memory read data and one-cycle acknowledge
//   err                         sticky memory timeout flag
//   miss_cnt, wb_cnt            completed refills / writebacks (wrapping)
module cache_refill_ctrl #(
    parameter int XLEN      = 32,
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 cpu_access,
    input  logic [XLEN-1:0]      cpu_addr,
    input  logic                 cache_hit,
    input  logic                 cache_dirty,
    input  logic [XLEN-1:0]      cache_miss_addr,
    input  logic [XLEN-1:0]      cache_data_out,
    output logic                 fill_sel,
    output logic                 fill_we,
    output logic [XLEN-1:0]      fill_addr,
    output logic [XLEN-1:0]      fill_data,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_ack,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic [CNT_WIDTH-1:0] wb_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_WRITE,
        S_RESUME
    } state_t;

    // Last wait count before the abort; the request has then been up TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [XLEN-1:0]       r_req_addr;
    logic [XLEN-1:0]       r_victim_addr;
    logic [XLEN-1:0]       r_victim_data;
    logic [XLEN-1:0]       r_fill_data;
    logic [7:0]            r_wait;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;
    logic [CNT_WIDTH-1:0]  r_wb_cnt;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [XLEN-1:0]       r_mem_addr;
    logic [XLEN-1:0]       r_mem_wdata;

    logic                  w_miss;
    logic                  w_busy_mem;
    logic                  w_timeout;
    logic                  w_enter_mem;
    logic [XLEN-1:0]       w_cpu_blk;

    assign w_cpu_blk  = cpu_addr & ~(XLEN'(3));
    assign w_miss     = cpu_access && !cache_hit;
    assign w_busy_mem = (r_state == S_WB) || (r_state == S_FILL);
    assign w_timeout  = w_busy_mem && !mem_ack && (r_wait == WAIT_LAST);
    // A fresh request phase starts whenever the next state is WB/FILL and differs from now.
    assign w_enter_mem = ((w_next_state == S_WB) || (w_next_state == S_FILL))
                         && (w_next_state != r_state);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b1;
        fill_sel     = 1'b0;
        fill_we      = 1'b0;
        fill_addr    = '0;
        case (r_state)
            S_IDLE: begin
                stall = w_miss;
                if (w_miss) begin
                    w_next_state = cache_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    w_next_state = S_FILL;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    w_next_state = S_WRITE;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WRITE: begin
                fill_sel     = 1'b1;
                fill_we      = 1'b1;
                fill_addr    = r_req_addr;
                w_next_state = S_RESUME;
            end
            S_RESUME: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_req_addr    <= '0;
            r_victim_addr <= '0;
            r_victim_data <= '0;
            r_fill_data   <= '0;
            r_wait        <= '0;
            r_err         <= 1'b0;
            r_miss_cnt    <= '0;
            r_wb_cnt      <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            if (r_state == S_IDLE && w_miss) begin
                r_req_addr    <= w_cpu_blk;
                r_victim_addr <= cache_miss_addr;
                r_victim_data <= cache_data_out;
            end

            if (w_enter_mem) begin
                r_wait <= '0;
            end else if (w_busy_mem) begin
                r_wait <= r_wait + 8'd1;
            end

            // Memory-side outputs load on phase entry, hold while waiting, clear on exit.
            if (w_enter_mem && w_next_state == S_WB) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= cache_miss_addr;
                r_mem_wdata <= cache_data_out;
            end else if (w_enter_mem) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= (r_state == S_IDLE) ? w_cpu_blk : r_req_addr;
                r_mem_wdata <= '0;
            end else if (w_next_state != S_WB && w_next_state != S_FILL) begin
                r_mem_req   <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= '0;
                r_mem_wdata <= '0;
            end

            if (r_state == S_WB && mem_ack) begin
                r_wb_cnt <= r_wb_cnt + 1'b1;
            end
            if (r_state == S_FILL && mem_ack) begin
                r_fill_data <= mem_rdata;
            end
            if (r_state == S_WRITE) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign fill_data = r_fill_data;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;
    assign miss_cnt  = r_miss_cnt;
    assign wb_cnt    = r_wb_cnt;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        cpu_access = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cache_hit = 1'b0;
    logic        cache_dirty = 1'b0;
    logic [31:0] cache_miss_addr = '0;
    logic [31:0] cache_data_out = '0;
    logic        fill_sel, fill_we, stall, mem_req, mem_we, err;
    logic [31:0] fill_addr, fill_data, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] miss_cnt, wb_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the counters and error flag should read.
    int unsigned exp_miss = 0;
    int unsigned exp_wb   = 0;
    logic        exp_err  = 1'b0;

    cache_refill_ctrl #(.XLEN(32), .TIMEOUT(TO), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_b(rst_b),
        .cpu_access(cpu_access), .cpu_addr(cpu_addr),
        .cache_hit(cache_hit), .cache_dirty(cache_dirty),
        .cache_miss_addr(cache_miss_addr), .cache_data_out(cache_data_out),
        .fill_sel(fill_sel), .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete miss as seen from the memory side: optional writeback of
    // wb_lat cycles, fill of fill_lat cycles, one write cycle, one resume cycle.
    task automatic do_miss(input logic [31:0] addr, input bit dirty,
                           input logic [31:0] vaddr, input logic [31:0] vdata,
                           input int wb_lat, input int fill_lat, input logic [31:0] rdata);
        logic [31:0] blk;
        int          stall_n;
        int          exp_len;
        blk = addr & 32'hFFFF_FFFC;
        @(negedge clk);
        cpu_access = 1'b1; cpu_addr = addr; cache_hit = 1'b0; cache_dirty = dirty;
        cache_miss_addr = vaddr; cache_data_out = vdata;
        #1;
        stall_n = 0;
        if (stall) stall_n++;
        chk("stall_on_miss", 32'(stall), 32'd1);
        if (dirty) begin
            for (int k = 1; k <= wb_lat; k++) begin
                @(negedge clk);
                if (stall) stall_n++;
                chk("wb_req", 32'(mem_req), 32'd1);
                chk("wb_we", 32'(mem_we), 32'd1);
                chk("wb_addr", mem_addr, vaddr);
                chk("wb_wdata", mem_wdata, vdata);
                chk("wb_fill_sel", 32'(fill_sel), 32'd0);
                // Busy-time input churn must not be re-sampled.
                cpu_access = 1'($urandom); cpu_addr = $urandom;
                cache_miss_addr = $urandom; cache_data_out = $urandom;
                mem_ack = (k == wb_lat);
            end
            exp_wb++;
        end
        for (int k = 1; k <= fill_lat; k++) begin
            @(negedge clk);
            if (stall) stall_n++;
            chk("fill_req", 32'(mem_req), 32'd1);
            chk("fill_we_mem", 32'(mem_we), 32'd0);
            chk("fill_addr_mem", mem_addr, blk);
            chk("fill_sel_busy", 32'(fill_sel), 32'd0);
            cpu_access = 1'($urandom); cpu_addr = $urandom;
            mem_ack   = (k == fill_lat);
            mem_rdata = (k == fill_lat) ? rdata : $urandom;
        end
        @(negedge clk);
        if (stall) stall_n++;
        mem_ack = 1'b0; mem_rdata = $urandom;
        chk("write_sel", 32'(fill_sel), 32'd1);
        chk("write_we", 32'(fill_we), 32'd1);
        chk("write_addr", fill_addr, blk);
        chk("write_data", fill_data, rdata);
        chk("write_memreq", 32'(mem_req), 32'd0);
        exp_miss++;
        @(negedge clk);
        if (stall) stall_n++;
        cpu_access = 1'b0; cache_hit = 1'b1;
        chk("resume_we", 32'(fill_we), 32'd0);
        chk("resume_stall", 32'(stall), 32'd1);
        chk("miss_cnt", miss_cnt, exp_miss);
        chk("wb_cnt", wb_cnt, exp_wb);
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
        chk("err_flag", 32'(err), 32'(exp_err));
        exp_len = 3 + fill_lat + (dirty ? wb_lat : 0);
        chk("stall_len", 32'(stall_n), 32'(exp_len));
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
        chk("rst_wb", wb_cnt, 32'd0);
        chk("rst_fill_sel", 32'(fill_sel), 32'd0);
        chk("rst_fill_data", fill_data, 32'd0);
        rst_b = 1'b1;

        // Hits: no stall, no memory traffic, stray acks ignored
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cpu_access = 1'b1; cache_hit = 1'b1; cpu_addr = $urandom;
            mem_ack = 1'($urandom);
            #1;
            chk("hit_stall", 32'(stall), 32'd0);
            chk("hit_req", 32'(mem_req), 32'd0);
        end
        @(negedge clk);
        cpu_access = 1'b0; mem_ack = 1'b0;
        chk("hit_miss_cnt", miss_cnt, 32'd0);

        // Directed clean miss, dirty miss, zero-wait memory
        do_miss(32'h0000_2004, 1'b0, 32'h0, 32'h0, 0, 3, 32'hDEAD_BEEF);
        do_miss(32'h0000_2004, 1'b1, 32'h0000_0004, 32'h1122_3344, 2, 2, 32'hCAFE_F00D);
        do_miss(32'h0000_3007, 1'b0, 32'h0, 32'h0, 0, 1, 32'h0BAD_F00D);
        do_miss(32'h0000_4008, 1'b1, 32'h0001_0008, 32'h5566_7788, 1, 1, 32'h1234_5678);
        do_miss(32'h0000_500C, 1'b0, 32'h0, 32'h0, 0, TO - 1, 32'h7777_0000);

        // Randomized misses
        for (int i = 0; i < 20; i++) begin
            do_miss($urandom, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
                    int'($urandom_range(1, TO - 1)), int'($urandom_range(1, TO - 1)), $urandom);
        end

        // Timeout: request held TO cycles, then dropped with err set
        begin
            bit saw_we;
            saw_we = 1'b0;
            @(negedge clk);
            cpu_access = 1'b1; cpu_addr = 32'h0000_6000; cache_hit = 1'b0; cache_dirty = 1'b0;
            for (int k = 1; k <= TO; k++) begin
                @(negedge clk);
                cpu_access = 1'b0;
                if (fill_we) saw_we = 1'b1;
                chk("to_req_held", 32'(mem_req), 32'd1);
            end
            @(negedge clk);
            if (fill_we) saw_we = 1'b1;
            exp_err = 1'b1;
            chk("to_req_drop", 32'(mem_req), 32'd0);
            chk("to_err", 32'(err), 32'd1);
            chk("to_stall", 32'(stall), 32'd0);
            chk("to_miss_cnt", miss_cnt, exp_miss);
            chk("to_no_write", 32'(saw_we), 32'd0);
        end
        do_miss(32'h0000_7004, 1'b1, 32'h0000_8004, 32'hA5A5_5A5A, 2, 3, 32'h3C3C_C3C3);

        // Reset in the middle of a fill
        @(negedge clk);
        cpu_access = 1'b1; cpu_addr = 32'h0000_9000; cache_hit = 1'b0; cache_dirty = 1'b0;
        @(negedge clk);
        cpu_access = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        exp_miss = 0; exp_wb = 0; exp_err = 1'b0;
        chk("mr_stall", 32'(stall), 32'd0);
        chk("mr_req", 32'(mem_req), 32'd0);
        chk("mr_addr", mem_addr, 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_miss", miss_cnt, 32'd0);
        chk("mr_wb", wb_cnt, 32'd0);
        chk("mr_fill_data", fill_data, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        do_miss(32'h0000_A004, 1'b1, 32'h0000_B004, 32'h0F0F_F0F0, 1, 2, 32'h9999_8888);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Memory-side miss handler for the direct-mapped, write-allocate data cache (one 4-byte block per line, 2048 lines, 19-bit tag).
- On a CPU access that misses, stalls the pipeline, writes the dirty victim block back to main memory, fetches the requested block, writes it into the cache, then releases the stall.
- Sits between the cache and the main-memory request/acknowledge port and owns the cache write port while it is active.

Parameters:
XLEN, 32, address and data width.
TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting the transfer.
CNT_WIDTH, 32, width of the miss and writeback statistics counters.

Ports:
clk  input  1  clock, all state on rising edge
rst_b  input  1  asynchronous active-low reset
cpu_access  input  1  load or store pending this cycle
cpu_addr  input  32  byte address of the pending access
cache_hit  input  1  cache hit for cpu_addr
cache_dirty  input  1  dirty bit of the line indexed by cpu_addr
cache_miss_addr  input  32  victim block address {tag, index, 2'b00}
cache_data_out  input  32  victim block as {byte3, byte2, byte1, byte0}, word read (is_byte=0)
fill_sel  output  1  1 = controller drives the cache addr/we/data_in/is_byte mux; is_byte is forced to 0
fill_we  output  1  cache write enable during fill
fill_addr  output  32  cache address during fill
fill_data  output  32  block written into the cache
stall  output  1  holds the CPU pipeline
mem_req  output  1  memory request, held until acknowledged
mem_we  output  1  1 = write (writeback), 0 = read (fill)
mem_addr  output  32  block-aligned memory address
mem_wdata  output  32  writeback data
mem_rdata  input  32  fill data, valid while mem_ack=1
mem_ack  input  1  one-cycle memory acknowledge
err  output  1  sticky timeout flag
miss_cnt  output  CNT_WIDTH  completed refills
wb_cnt  output  CNT_WIDTH  completed writebacks

Behaviour:
- Reset (rst_b=0, asynchronous): state=IDLE. All outputs are 0, including err and both counters. Latched registers are cleared. A reset asserted mid-transfer aborts the transfer without completing it.
- States: IDLE, WB, FILL, WRITE, RESUME.
- stall is combinational: (state==IDLE && cpu_access && !cache_hit) || state!=IDLE.
- IDLE: on cpu_access && !cache_hit, the controller latches:
  - req_addr = {cpu_addr[31:2], 2'b00}
  - victim_addr = cache_miss_addr
  - victim_data = cache_data_out
  - Next state is WB if cache_dirty=1, otherwise FILL.
  - Nothing happens on a hit or when cpu_access=0.
- WB: mem_req=1, mem_we=1, mem_addr=victim_addr, mem_wdata=victim_data.
  - On mem_ack: wb_cnt+1 and go to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr=req_addr.
  - On mem_ack: latch mem_rdata into fill_data and go to WRITE.
- WRITE: fill_sel=1, fill_we=1, fill_addr=req_addr for exactly one cycle.
  - This write installs the new tag, sets valid, and leaves the line clean (tag mismatch on write clears dirty).
  - miss_cnt+1, then go to RESUME.
- RESUME: one cycle with stall=1 so the cache hit path settles; then go to IDLE.
- mem_req and mem_addr/mem_we/mem_wdata are registered and stable from the first cycle of WB/FILL until the cycle mem_ack is sampled. They drop the cycle after the ack.
- mem_ack is ignored while mem_req=0. An ack in the first request cycle is legal (minimum 1-cycle memory latency).
- Timeout: an 8-bit wait counter is cleared on entry to WB or FILL and increments each cycle without an ack. When it reaches TIMEOUT:
  - err is set (sticky until reset), mem_req is dropped, and the state returns to IDLE.
  - No counter increments and no cache write occur.
- Latched values are not re-sampled while busy. Changes on cpu_addr or cpu_access during WB/FILL/WRITE are ignored.
- Both counters wrap modulo 2^CNT_WIDTH.
- fill_sel=0 in every state except WRITE, so CPU stores go directly to the cache.
- Refill latency: a clean miss costs 3 cycles plus memory latency; a dirty miss adds the writeback latency.

Test Plan:
- Clean miss: cpu_addr=0x0000_2004, cache_hit=0, cache_dirty=0; mem acks after 3 cycles with mem_rdata=0xDEADBEEF -> single read with mem_addr=0x0000_2004, mem_we=0; one WRITE cycle with fill_data=0xDEADBEEF; miss_cnt=1, wb_cnt=0; stall drops after RESUME.
- Dirty miss: cache_dirty=1, cache_miss_addr=0x0000_0004, cache_data_out=0x11223344, cpu_addr=0x0000_2004 -> write of 0x11223344 to 0x0000_0004, then read of 0x0000_2004; wb_cnt=1, miss_cnt=1.
- Hit: cpu_access=1, cache_hit=1 for 10 cycles -> stall=0, mem_req=0, state remains IDLE.
- Zero-wait memory: mem_ack asserted in the first FILL cycle -> WRITE occurs on the next cycle; total stall length is 4 cycles.
- Timeout: TIMEOUT=8, mem_ack never asserted -> mem_req drops after 8 cycles, err=1, miss_cnt=0, no fill_we; err stays 1 on later misses.
- Reset mid-FILL: rst_b=0 for 1 cycle -> all outputs 0 immediately; a later miss completes normally.
